regfile_bank: RTL

- Storage core of the register file: 32 registers of WIDTH bits, with one write port.
- The write is pipelined through a one-entry pending-write stage before it commits to the array.
- All 32 register values are driven on a flattened bus. The downstream 32:1 read-select muxes (one per bit per read port) consume this bus.
- Register 31 is the hardwired zero register.

---
 rtl/regfile_bank.sv | 92 +++++++++
 1 files changed

// File: rtl/regfile_bank.sv
// Purpose: 32 x WIDTH register storage with a one-entry pending-write stage; reg 31 reads zero. Optional bypass via REGFILE_BYPASS_EN.
// Latency: write sampled at edge N commits to the array at edge N+1 (with REGFILE_BYPASS_EN it is visible on regs_flat after edge N).
// Backpressure: none; one write per cycle is always accepted, and writes to reg 31 are dropped at capture.
module regfile_bank #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [4:0]            wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [32*WIDTH-1:0]   regs_flat,
    output logic                  pend_valid,
    output logic [4:0]            pend_addr,
    output logic [CNT_W-1:0]      commit_cnt
);

    localparam logic [4:0] ZERO_REG = 5'd31;

    logic [WIDTH-1:0] pend_data;
    // Register 31 is hardwired to zero, so only entries 0..30 hold state.
    logic [WIDTH-1:0] regs [0:30];
    logic [30:0]      wr_sel;

    // Capture stage: latch an incoming write unless it targets the zero register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid <= 1'b0;
            pend_addr  <= 5'd0;
            pend_data  <= '0;
        end else if (wr_en && (wr_addr != ZERO_REG)) begin
            pend_valid <= 1'b1;
            pend_addr  <= wr_addr;
            pend_data  <= wr_data;
        end else begin
            // pend_data deliberately holds; only valid/addr are cleared.
            pend_valid <= 1'b0;
            pend_addr  <= 5'd0;
        end
    end

    // One-hot decode of the pending write address, qualified by pend_valid.
    always_comb begin
        wr_sel = '0;
        for (int k = 0; k < 31; k++) begin
            wr_sel[k] = pend_valid && (pend_addr == 5'(k));
        end
    end

    // Commit stage: move the pending data into the selected array entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 31; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 31; k++) begin
                if (wr_sel[k]) begin
                    regs[k] <= pend_data;
                end
            end
        end
    end

    // Count committed writes; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_cnt <= '0;
        end else if (pend_valid) begin
            commit_cnt <= commit_cnt + CNT_W'(1);
        end
    end

    // Drive the flattened read bus; slice 31 stays zero.
    always_comb begin
        regs_flat = '0;
        for (int k = 0; k < 31; k++) begin
`ifdef REGFILE_BYPASS_EN
            // Forward the in-flight write so readers see it one cycle early.
            if (wr_sel[k]) begin
                regs_flat[k*WIDTH +: WIDTH] = pend_data;
            end else begin
                regs_flat[k*WIDTH +: WIDTH] = regs[k];
            end
`else
            regs_flat[k*WIDTH +: WIDTH] = regs[k];
`endif
        end
    end

endmodule
